multibuffer_queue: RTL and testbench



---
 rtl/multibuffer_queue.sv | 99 +++++++++
 tb/tb_multibuffer_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multibuffer_queue.sv
// Width-converting FIFO: wide entries in, narrow words out (least-significant word first).
// M_BUFF_NUM equal buffers are laid end to end and addressed as one circular entry queue.
module multibuffer_queue #(
    parameter int Q_DATA_WIDTH      = 128,
    parameter int INFO_WIDTH        = 10,
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_OUT_WIDTH    = 32,
    parameter int M_BUFF_NUM        = 4,
    parameter int M_BUFF_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_en,
    input  logic [Q_DATA_WIDTH-1:0]   data_in,
    output logic                      waitrequest,
    input  logic                      read_en,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      data_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full
);

    localparam int WPE    = Q_DATA_WIDTH / DATA_OUT_WIDTH;
    localparam int EPB    = (2 ** M_BUFF_ADDR_WIDTH) / Q_DATA_WIDTH;
    localparam int CAP    = M_BUFF_NUM * EPB;
    localparam int PTR_W  = (CAP > 1) ? $clog2(CAP) : 1;
    localparam int CNT_W  = $clog2(CAP + 1);
    localparam int WIDX_W = (WPE > 1) ? $clog2(WPE) : 1;

    // Reject configurations the word slicing cannot support.
    if ((Q_DATA_WIDTH % DATA_OUT_WIDTH) != 0 || EPB < 1 || INFO_WIDTH < 0 || ADDR_WIDTH < 0) begin : g_bad_cfg
        $error("multibuffer_queue: invalid parameter combination");
    end

    logic [Q_DATA_WIDTH-1:0] mem [CAP];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [WIDX_W-1:0] widx;
    logic [CNT_W-1:0]  count;

    logic do_write;
    logic do_read;
    logic free_entry;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CAP - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_write   = write_en && !full;
    assign do_read    = read_en && !empty;
    assign free_entry = do_read && (widx == WIDX_W'(WPE - 1));

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(CAP));
    assign almost_full = (count >= CNT_W'(CAP - 1));
    assign waitrequest = full;

    // NOTE: the storage array has no reset; stale entries are unreachable once the pointers and count clear.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            widx       <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= do_read;
            if (do_write) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_read) begin
                data_out <= mem[rd_ptr][widx * DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
                if (free_entry) begin
                    widx   <= '0;
                    rd_ptr <= next_ptr(rd_ptr);
                end else begin
                    widx <= widx + 1'b1;
                end
            end
            // A freed head entry and an accepted write cancel out.
            case ({do_write, free_entry})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_multibuffer_queue.sv
// Directed self-checking bench for multibuffer_queue at default parameters.
module tb_multibuffer_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         write_en;
    logic [127:0] data_in;
    logic         waitrequest;
    logic         read_en;
    logic [31:0]  data_out;
    logic         data_valid;
    logic         full;
    logic         empty;
    logic         almost_full;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] words [32];

    multibuffer_queue dut (
        .clk         (clk),
        .rst         (rst),
        .write_en    (write_en),
        .data_in     (data_in),
        .waitrequest (waitrequest),
        .read_en     (read_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input int base);
        return {32'(base + 3), 32'(base + 2), 32'(base + 1), 32'(base)};
    endfunction

    task automatic write_entry(input logic [127:0] d);
        write_en = 1'b1;
        data_in  = d;
        tick();
        write_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_full"}, full, 1'b0);
        check({tag, "_afull"}, almost_full, 1'b0);
        check({tag, "_wreq"}, waitrequest, 1'b0);
        check({tag, "_dv"}, data_valid, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_idle("reset");
        check("reset_dout", data_out, 32'd0);

        // Eight entries of random words, then a continuous drain.
        for (int e = 0; e < 8; e++) begin
            for (int k = 0; k < 4; k++) words[e*4+k] = $urandom;
            write_entry({words[e*4+3], words[e*4+2], words[e*4+1], words[e*4]});
        end
        read_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            check($sformatf("rand_dv%0d", i), data_valid, 1'b1);
            check($sformatf("rand_w%0d", i), data_out, words[i]);
        end
        read_en = 1'b0;
        tick();
        check_idle("rand_drained");

        // Fill to capacity with ascending words, then a dropped write.
        for (int e = 0; e < 32; e++) begin
            write_entry(mk(4 * e));
            if (e == 30) begin
                check("fill31_afull", almost_full, 1'b1);
                check("fill31_full", full, 1'b0);
            end
        end
        check("fill32_full", full, 1'b1);
        check("fill32_afull", almost_full, 1'b1);
        check("fill32_wreq", waitrequest, 1'b1);
        check("fill32_empty", empty, 1'b0);
        write_entry(mk(32'hDEAD0));
        check("drop_full", full, 1'b1);
        read_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            tick();
            check($sformatf("fill_dv%0d", i), data_valid, 1'b1);
            check($sformatf("fill_w%0d", i), data_out, 32'(i));
            if (i == 3) check("fill_unfull", full, 1'b0);
        end
        tick();
        check("over_dv", data_valid, 1'b0);
        check("over_empty", empty, 1'b1);
        check("over_hold", data_out, 32'd127);
        read_en = 1'b0;
        tick();
        check_idle("fill_drained");

        // Back-to-back words of a single entry.
        write_entry({32'd3, 32'd2, 32'd1, 32'd0});
        read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b2b_dv%0d", i), data_valid, 1'b1);
            check($sformatf("b2b_w%0d", i), data_out, 32'(i));
        end
        tick();
        check("b2b_dv4", data_valid, 1'b0);
        check("b2b_hold", data_out, 32'd3);
        read_en = 1'b0;

        // Concurrent producer/consumer with pointer wrap-around.
        fork
            begin : producer
                for (int e = 0; e < 256; e++) begin
                    logic acc;
                    int   budget;
                    budget   = 0;
                    write_en = 1'b1;
                    data_in  = mk(4 * e);
                    do begin
                        acc = !waitrequest;
                        tick();
                        budget++;
                    end while (!acc && budget < 2000);
                    if (!acc) begin
                        check("prod_timeout", acc, 1'b1);
                        break;
                    end
                end
                write_en = 1'b0;
            end
            begin : consumer
                int nxt;
                int cyc;
                nxt = 0;
                cyc = 0;
                repeat (55) tick();
                read_en = 1'b1;
                while (nxt < 1024 && cyc < 5000) begin
                    tick();
                    cyc++;
                    if (data_valid) begin
                        check("stream_word", data_out, 32'(nxt));
                        nxt++;
                    end
                end
                read_en = 1'b0;
                check("stream_count", 32'(nxt), 32'd1024);
            end
        join
        tick();
        check_idle("stream_end");

        // Half-cycle reset pulse with ten entries queued mid-read.
        for (int e = 0; e < 10; e++) write_entry(mk(1000 + 4 * e));
        read_en = 1'b1;
        repeat (2) tick();
        check("pre_rst_dout", data_out, 32'd1001);
        read_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_dout", data_out, 32'd0);
        #3 rst = 1'b0;
        tick();
        check_idle("post_rst");
        write_entry(mk(2000));
        read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_w%0d", i), data_out, 32'(2000 + i));
        end
        tick();
        check("post_rst_dv4", data_valid, 1'b0);
        check("post_rst_empty", empty, 1'b1);
        read_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
